// File: rtl/rv_muldiv_seq.sv
// Sequential RISC-V M-extension unit: radix-2 shift-add multiply and
// restoring divide, one bit per cycle, with valid/ready on both sides.
// Signed ops run on magnitudes and are sign-corrected when DONE is entered.
module rv_muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      funct3_i,
    input  logic [6:0]      funct7_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            illegal_o,
    output logic            busy_o
);

    localparam int            CW   = $clog2(XLEN + 1);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   opb_q;
    logic              neg_q;
    logic [CW-1:0]     cnt_q;
    logic [XLEN-1:0]   res_q;
    logic              illegal_q;

    // Two's complement negate helpers used for magnitude extraction and
    // final sign correction.
    function automatic logic [XLEN-1:0] cneg_x(input logic [XLEN-1:0] v, input logic n);
        return n ? ((~v) + XLEN'(1)) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] cneg_2x(input logic [2*XLEN-1:0] v, input logic n);
        return n ? ((~v) + (2*XLEN)'(1)) : v;
    endfunction

    // Request decode: operand signedness, magnitudes and the skip cases.
    logic                   hs;
    logic                   is_div, a_sgn, b_sgn, a_neg, b_neg;
    logic signed [XLEN-1:0] rs1_s, rs2_s;
    logic [XLEN-1:0]        a_mag, b_mag;
    logic                   illegal_in, div_zero, div_ovf, skip;
    logic [XLEN-1:0]        skip_res;
    logic                   neg_in;

    always_comb begin
        hs         = valid_i && (state_q == IDLE);
        rs1_s      = rs1_i;
        rs2_s      = rs2_i;
        is_div     = funct3_i[2];
        a_sgn      = (funct3_i == 3'd1) || (funct3_i == 3'd2) ||
                     (funct3_i == 3'd4) || (funct3_i == 3'd6);
        b_sgn      = (funct3_i == 3'd1) || (funct3_i == 3'd4) || (funct3_i == 3'd6);
        a_neg      = a_sgn && (rs1_s < 0);
        b_neg      = b_sgn && (rs2_s < 0);
        a_mag      = cneg_x(rs1_i, a_neg);
        b_mag      = cneg_x(rs2_i, b_neg);
        illegal_in = (funct7_i != 7'h01);
        div_zero   = is_div && (rs2_i == '0);
        div_ovf    = is_div && !funct3_i[0] && (rs1_i == MOST_NEG) && (rs2_s == -1);
        skip       = illegal_in || div_zero || div_ovf;
        skip_res   = '0;
        if (illegal_in)
            skip_res = '0;
        else if (div_zero)
            skip_res = funct3_i[1] ? rs1_i : '1;
        else if (div_ovf)
            skip_res = funct3_i[1] ? '0 : MOST_NEG;
        // Remainder takes the dividend's sign; everything else the xor.
        neg_in = (is_div && funct3_i[1]) ? a_neg : (a_neg ^ b_neg);
    end

    // One iteration of shift-add multiply or restoring divide, plus the
    // sign-corrected result used on the final step.
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_sh, rem_diff;
    logic [2*XLEN-1:0] acc_step, prod;
    logic [XLEN-1:0]   fin_res;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        rem_sh   = acc_q[2*XLEN-1:XLEN-1];
        rem_diff = rem_sh - {1'b0, opb_q};
        if (!op_q[2])
            acc_step = {mul_sum, acc_q[XLEN-1:1]};
        else if (rem_sh >= {1'b0, opb_q})
            acc_step = {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        else
            acc_step = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        prod = cneg_2x(acc_step, neg_q);
        if (!op_q[2])
            fin_res = (op_q == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        else if (op_q[1])
            fin_res = cneg_x(acc_step[2*XLEN-1:XLEN], neg_q);
        else
            fin_res = cneg_x(acc_step[XLEN-1:0], neg_q);
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic and output decode.
    always_comb begin
        state_d   = state_q;
        ready_o   = 1'b0;
        busy_o    = 1'b0;
        valid_o   = 1'b0;
        illegal_o = 1'b0;
        result_o  = '0;
        case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                if (hs) state_d = skip ? DONE : CALC;
            end
            CALC: begin
                busy_o = 1'b1;
                if (cnt_q == LAST) state_d = DONE;
            end
            DONE: begin
                busy_o    = 1'b1;
                valid_o   = 1'b1;
                illegal_o = illegal_q;
                result_o  = res_q;
                if (ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, iteration and result register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q      <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            neg_q     <= 1'b0;
            cnt_q     <= '0;
            res_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hs) begin
                        op_q      <= funct3_i;
                        acc_q     <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
                        opb_q     <= is_div ? b_mag : a_mag;
                        neg_q     <= neg_in;
                        cnt_q     <= '0;
                        illegal_q <= illegal_in;
                        res_q     <= skip_res;
                    end
                end
                CALC: begin
                    acc_q <= acc_step;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST) res_q <= fin_res;
                end
                default: ;
            endcase
        end
    end

endmodule
